// File: rtl/fifo_to_axis_pkg.sv
// Shared field layout of the 144-bit replay FIFO word and the tuser port offsets.
// Also holds the helper that turns a valid-byte count into a tkeep mask.
package fifo_to_axis_pkg;

    localparam int EOP_BIT     = 143;
    localparam int BYTES_M1_HI = 142;
    localparam int BYTES_M1_LO = 139;
    localparam int DATA_HI     = 127;

    localparam int SRC_PORT_LO = 16;
    localparam int DST_PORT_LO = 24;

    // n valid bytes (0..8) -> low n bits set
    function automatic logic [7:0] keep_from_count(input logic [3:0] n);
        return 8'((9'd1 << n) - 9'd1);
    endfunction

endpackage

// File: rtl/fifo_to_axis.sv
// Drains a first-word-fall-through replay FIFO and emits each 144-bit word as two
// 64-bit AXI4-Stream beats, trimming the final beat of a packet from its eop/bytes_m1 bits.
module fifo_to_axis
    import fifo_to_axis_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int FIFO_DATA_WIDTH      = 144,
    parameter int PKT_COUNT_WIDTH      = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sw_rst,
    input  logic [FIFO_DATA_WIDTH-1:0]        fifo_dout,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic [7:0]                        src_port,
    input  logic [7:0]                        dst_port,
    input  logic                              q_enable,
    output logic [PKT_COUNT_WIDTH-1:0]        pkt_count
);

    logic [C_M_AXIS_DATA_WIDTH-1:0]   r_tdata;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] r_tkeep;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  r_tuser;
    logic                             r_tvalid;
    logic                             r_tlast;
    logic                             r_half;
    logic                             r_in_pkt;
    logic [PKT_COUNT_WIDTH-1:0]       r_pkt_count;

    logic                             w_eop;
    logic [3:0]                       w_bm1;
    logic                             w_short;
    logic                             w_load;
    logic                             w_last_nxt;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   w_tdata_nxt;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] w_tkeep_nxt;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  w_tuser_nxt;
    logic                             w_unused;

    assign w_eop    = fifo_dout[EOP_BIT];
    assign w_bm1    = fifo_dout[BYTES_M1_HI:BYTES_M1_LO];
    assign w_unused = ^fifo_dout[BYTES_M1_LO-1:DATA_HI+1];

    // An eop word of at most 8 bytes fits entirely in its low beat.
    assign w_short = w_eop && !w_bm1[3];

    // q_enable only holds back the first beat; once in a packet it runs to tlast.
    assign w_load = (!r_tvalid || m_axis_tready) && !fifo_empty && (r_in_pkt || q_enable);

    // The word is popped on its final beat, so the head never changes between halves.
    assign fifo_rd_en = w_load && (r_half || w_short);

    assign w_last_nxt  = r_half ? w_eop : w_short;
    assign w_tdata_nxt = r_half ? fifo_dout[DATA_HI -: C_M_AXIS_DATA_WIDTH]
                                : fifo_dout[C_M_AXIS_DATA_WIDTH-1:0];
    assign w_tkeep_nxt = !w_last_nxt ? '1
                       : keep_from_count(r_half ? (w_bm1 - 4'd7) : (w_bm1 + 4'd1));

    always_comb begin
        w_tuser_nxt = '0;
        if (!r_in_pkt) begin
            w_tuser_nxt[SRC_PORT_LO +: 8] = src_port;
            w_tuser_nxt[DST_PORT_LO +: 8] = dst_port;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sw_rst) begin
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tuser     <= '0;
            r_half      <= 1'b0;
            r_in_pkt    <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            if (r_tvalid && m_axis_tready && r_tlast)
                r_pkt_count <= r_pkt_count + PKT_COUNT_WIDTH'(1);

            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_tdata_nxt;
                r_tkeep  <= w_tkeep_nxt;
                r_tlast  <= w_last_nxt;
                r_tuser  <= w_tuser_nxt;
                r_half   <= !r_half && !w_short;
                r_in_pkt <= !w_last_nxt;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_fifo_to_axis.sv
// Bench for fifo_to_axis: packets are modelled as byte streams, split into 8-byte beats
// and compared beat by beat; the FIFO is a queue popped on fifo_rd_en.
module tb_fifo_to_axis;

    logic         clk = 1'b0;
    logic         rst, sw_rst;
    logic [143:0] fifo_dout;
    logic         fifo_empty, fifo_rd_en;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [7:0]   src_port, dst_port;
    logic         q_enable;
    logic [31:0]  pkt_count;

    always #5 clk = ~clk;

    fifo_to_axis dut (
        .clk(clk), .rst(rst), .sw_rst(sw_rst),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .src_port(src_port), .dst_port(dst_port), .q_enable(q_enable), .pkt_count(pkt_count)
    );

    typedef struct {
        logic [63:0]  d;
        logic [7:0]   k;
        logic         l;
        logic [127:0] u;
        logic         f;
        int           nb;
    } beat_t;

    beat_t        exp_q[$];
    logic [143:0] fq[$];
    int           n_vec = 0, n_err = 0;
    int           exp_cnt = 0, cyc = 0, t0 = 0, pat = 0;
    logic         pop_pend = 0, clr_pend = 0, thru_on = 0;
    logic         prev_valid = 0, prev_hs = 0, q_en_prev = 0;
    logic [63:0]  prev_d;
    logic [7:0]   prev_k;
    logic         prev_l;
    logic [127:0] prev_u;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fq[0];
    endtask

    task automatic monitor();
        beat_t e;
        if (rst || sw_rst) begin
            exp_q.delete();
            exp_cnt    = 0;
            prev_valid = 0;
            prev_hs    = 0;
            pop_pend   = 0;
            clr_pend   = 1;
            return;
        end
        pop_pend = fifo_rd_en;
        if (fifo_rd_en) chk("rd_en_when_empty", 128'(fifo_empty), 128'(0));
        chk("pkt_count", 128'(pkt_count), 128'(exp_cnt));
        if (m_axis_tvalid) begin
            if (prev_valid && !prev_hs) begin
                chk("stall_tdata", 128'(m_axis_tdata), 128'(prev_d));
                chk("stall_tkeep", 128'(m_axis_tkeep), 128'(prev_k));
                chk("stall_tlast", 128'(m_axis_tlast), 128'(prev_l));
                chk("stall_tuser", m_axis_tuser, prev_u);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_beat", 128'(exp_q.size()), 128'(1));
            end else if (exp_q[0].f) begin
                chk("start_gated_by_q_enable", 128'(q_en_prev), 128'(1));
            end
        end
        if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tdata", 128'(m_axis_tdata), 128'(e.d));
            chk("tkeep", 128'(m_axis_tkeep), 128'(e.k));
            chk("tlast", 128'(m_axis_tlast), 128'(e.l));
            chk("tuser", m_axis_tuser, e.u);
            if (e.f) t0 = cyc;
            if (e.l) begin
                exp_cnt++;
                if (thru_on) chk("beats_back_to_back", 128'(cyc - t0 + 1), 128'(e.nb));
            end
        end
        prev_valid = m_axis_tvalid;
        prev_hs    = m_axis_tvalid && m_axis_tready;
        prev_d     = m_axis_tdata;
        prev_k     = m_axis_tkeep;
        prev_l     = m_axis_tlast;
        prev_u     = m_axis_tuser;
        q_en_prev  = q_enable;
        cyc++;
    endtask

    // Inputs change only here (#1 after the edge); outputs are checked on the falling edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (clr_pend) begin
            fq.delete();
            clr_pend = 0;
        end else if (pop_pend && fq.size() > 0) begin
            void'(fq.pop_front());
        end
        drive_fifo();
    endtask

    task automatic push_pkt(input int len);
        int           nw, nb, n;
        logic [7:0]   b[$];
        logic [143:0] w;
        beat_t        e;
        nw = (len + 15) / 16;
        nb = (len + 7) / 8;
        for (int i = 0; i < nw * 16; i++) b.push_back(8'($urandom));
        for (int k = 0; k < nw; k++) begin
            w = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
            for (int j = 0; j < 16; j++) w[j*8 +: 8] = b[k*16 + j];
            w[143] = (k == nw - 1);
            if (w[143]) w[142:139] = 4'((len - 1) % 16);
            fq.push_back(w);
        end
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < 8; j++) e.d[j*8 +: 8] = b[k*8 + j];
            n = len - 8 * k;
            if (n > 8) n = 8;
            e.k  = 8'((1 << n) - 1);
            e.l  = (k == nb - 1);
            e.f  = (k == 0);
            e.nb = nb;
            e.u  = '0;
            if (k == 0) begin
                e.u[23:16] = src_port;
                e.u[31:24] = dst_port;
            end
            exp_q.push_back(e);
        end
        drive_fifo();
    endtask

    // mode 0: tready=1; mode 1: tready 1,0,0,1 repeating; mode 2: random tready/q_enable
    task automatic wait_drain(input int lim, input int mode);
        int i = 0;
        while ((exp_q.size() > 0 || fq.size() > 0 || m_axis_tvalid) && i < lim) begin
            if (mode == 1) begin
                m_axis_tready = (pat % 4 == 0) || (pat % 4 == 3);
                pat++;
            end else if (mode == 2) begin
                m_axis_tready = ($urandom_range(0, 9) < 7);
                q_enable      = ($urandom_range(0, 9) < 8);
            end
            tick();
            i++;
        end
        if (i >= lim) chk("drain_timeout", 128'(exp_q.size() + fq.size() + 1), 128'(0));
        m_axis_tready = 1'b1;
        q_enable      = 1'b1;
    endtask

    task automatic reset_mid_pkt(input logic use_sw);
        m_axis_tready = 1'b1;
        q_enable      = 1'b1;
        push_pkt(64);
        repeat (3) tick();
        if (use_sw) sw_rst = 1'b1; else rst = 1'b1;
        tick();
        rst    = 1'b0;
        sw_rst = 1'b0;
        chk("mid_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("mid_rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("mid_rst_tlast", 128'(m_axis_tlast), 128'(0));
        src_port = 8'($urandom);
        dst_port = 8'($urandom);
        push_pkt(20);
        wait_drain(100, 0);
    endtask

    initial begin
        int base;
        rst = 1'b1; sw_rst = 1'b0;
        m_axis_tready = 1'b0; q_enable = 1'b0;
        src_port = 8'h00; dst_port = 8'h00;
        drive_fifo();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_tlast", 128'(m_axis_tlast), 128'(0));
        chk("rst_tdata", 128'(m_axis_tdata), 128'(0));
        chk("rst_tkeep", 128'(m_axis_tkeep), 128'(0));
        chk("rst_tuser", m_axis_tuser, 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));

        // single short word: tvalid one edge after the word appears
        thru_on = 1'b1; m_axis_tready = 1'b1; q_enable = 1'b1;
        src_port = 8'h11; dst_port = 8'h22;
        push_pkt(5);
        tick();
        chk("first_beat_latency", 128'(m_axis_tvalid), 128'(1));
        chk("short_tkeep", 128'(m_axis_tkeep), 128'(8'h1F));
        wait_drain(50, 0);
        push_pkt(64);
        wait_drain(50, 0);
        push_pkt(60);
        wait_drain(50, 0);
        push_pkt(16);
        push_pkt(8);
        push_pkt(9);
        wait_drain(50, 0);
        thru_on = 1'b0;

        // back-pressure across a 2-packet burst
        src_port = 8'h33; dst_port = 8'h44;
        push_pkt(40);
        push_pkt(27);
        wait_drain(200, 1);

        // q_enable dropped after beat 2: packet 1 completes, packet 2 waits
        base = exp_cnt;
        push_pkt(64);
        push_pkt(64);
        tick();
        tick();
        q_enable = 1'b0;
        repeat (12) tick();
        chk("q_enable_finish_pkt", 128'(pkt_count), 128'(base + 1));
        chk("q_enable_hold_next", 128'(m_axis_tvalid), 128'(0));
        q_enable = 1'b1;
        wait_drain(100, 0);

        reset_mid_pkt(1'b0);
        reset_mid_pkt(1'b1);

        for (int b = 0; b < 25; b++) begin
            src_port = 8'($urandom);
            dst_port = 8'($urandom);
            for (int p = 0; p < $urandom_range(1, 6); p++) push_pkt($urandom_range(1, 100));
            wait_drain(3000, 2);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_to_axis.md
# fifo_to_axis

Downstream of the SRAM replay reader. Drains one per-queue 144-bit replay FIFO (first-word-fall-through) and emits each stored packet as a 64-bit AXI4-Stream master with NetFPGA-style tuser. One instance is placed per output queue (q0..q3), between the queue FIFO and the output port arbiter. Each FIFO word is split into two beats, and the last beat of each packet is trimmed using the word's control bits.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 64: output tdata width; fixed, only 64 supported.
- C_M_AXIS_TUSER_WIDTH, 128: output tuser width.
- FIFO_DATA_WIDTH, 144: FIFO word width.
- PKT_COUNT_WIDTH, 32: packet counter width.

Ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- sw_rst  in  1  software reset, synchronous, active-high; same effect as rst.
- fifo_dout  in  144  FIFO head word, valid while fifo_empty=0.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pops the head word; combinational.
- m_axis_tdata  out  64  stream data.
- m_axis_tkeep  out  8  byte enables.
- m_axis_tuser  out  128  [23:16]=src_port and [31:24]=dst_port on the first beat; all other bits are 0.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of packet.
- src_port, dst_port  in  8 each  sampled at the first beat of each packet.
- q_enable  in  1  gates only the start of a packet.
- pkt_count  out  32  packets fully sent.

## Operation
- FIFO word format:
  - [127:0] packet bytes; byte 0 is at [7:0]. The low beat is [63:0] and the high beat is [127:64].
  - [143] eop.
  - [142:139] bytes_m1 = valid bytes in an eop word minus 1, range 0..15. Ignored when eop=0; a non-eop word is always 16 bytes.
  - [138:128] reserved, ignored.
- State: half (0 = low beat next, 1 = high beat next) and in_pkt (1 after the first beat, cleared when a tlast beat is loaded).
- Load condition: load = (!m_axis_tvalid || m_axis_tready) && !fifo_empty && (in_pkt || q_enable).
  - When load=0 and m_axis_tready=1, m_axis_tvalid drops to 0.
  - When load=0 and m_axis_tready=0, the output holds.
- Load with half=0:
  - tdata=[63:0].
  - If eop and bytes_m1<8: tkeep=(2^(bytes_m1+1))-1, tlast=1, fifo_rd_en=1, half stays 0.
  - Otherwise: tkeep=8'hFF, tlast=0, half becomes 1.
- Load with half=1:
  - tdata=[127:64], fifo_rd_en=1, half becomes 0.
  - If eop: tkeep=(2^(bytes_m1-7))-1, tlast=1.
  - Otherwise: tkeep=8'hFF, tlast=0.
- tuser: loaded as {96'b0, dst_port, src_port, 16'b0} when in_pkt=0, otherwise 0.
- q_enable deasserted mid-packet: has no effect; the packet completes.
- pkt_count: increments on each tvalid&&tready&&tlast handshake and wraps modulo 2^32.

## Timing
- Reset values: m_axis_tvalid=0, tlast=0, tdata/tkeep/tuser=0, half=0, in_pkt=0, pkt_count=0. Reset mid-packet abandons the packet; the FIFO is reset by its owner on the same rst/sw_rst.
- Latency: a word at the FIFO head with the output idle gives tvalid on the next edge.
- Throughput: one beat per cycle while tready=1, i.e. 2 cycles per non-final FIFO word.
- Outputs are registered: tdata, tkeep, tlast and tuser are stable while tvalid=1 and tready=0.
- fifo_rd_en asserts only in a load cycle and never when fifo_empty=1.
- FIFO empty between the halves of one word cannot occur, because the word is popped only on its last beat.

## Structure
- A shared package holds:
  - field constants: EOP_BIT=143, BYTES_M1_HI=142, BYTES_M1_LO=139, DATA_HI=127;
  - tuser offsets: SRC_PORT_LO=16, DST_PORT_LO=24;
  - a function mapping a valid-byte count to tkeep.
- Single module; no sub-module is needed.

## Test plan
1. 64-byte packet (4 words, last word eop, bytes_m1=15), tready=1 -> 8 beats on consecutive cycles, all tkeep=FF, tlast on beat 8, tuser[23:16]=src_port on beat 1 only, pkt_count=1.
2. 60-byte packet (last word bytes_m1=11) -> 8 beats; beat 8 tkeep=8'h0F, tlast=1.
3. 5-byte packet (single eop word, bytes_m1=4) -> 1 beat, tkeep=8'h1F, tlast=1, one fifo_rd_en.
4. tready toggling 1,0,0,1 during a 2-packet burst -> no beat lost or duplicated, outputs stable while stalled, data order preserved.
5. q_enable dropped after beat 2 of a 4-word packet -> the packet finishes (8 beats); the next queued packet is not started until q_enable=1.
6. rst asserted mid-packet -> next cycle tvalid=0, pkt_count=0, half=0; after reset a new packet starts with tuser port fields on its first beat.
